instruction_fetch: RTL and testbench

//  IF stage of the 5-stage in-order RV32I core; directly upstream of decode/immediate generation.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/if_id_register.sv | 59 +++++
 rtl/instruction_fetch.sv | 177 +++++++++++++++++
 tb/tb_instruction_fetch.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared RV32I core types and constants
// FETCH_MISALIGN_CHECK_EN adds the FAULT fetch state.
package cpu_pkg;

   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
   localparam logic [6:0]  OPCODE_JAL        = 7'b1101111;
   localparam logic [6:0]  OPCODE_LUI        = 7'b0110111;
   localparam logic [6:0]  OPCODE_AUIPC      = 7'b0010111;
   localparam logic [6:0]  OPCODE_BRANCH     = 7'b1100011;
   localparam logic [6:0]  OPCODE_STORE      = 7'b0100011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DRAIN
`ifdef FETCH_MISALIGN_CHECK_EN
      , S_FAULT
`endif
   } fetch_state_t;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

   function automatic imm_sel_t imm_sel_for_opcode(input logic [6:0] opcode);
      imm_sel_t sel;
      case (opcode)
         OPCODE_JAL:                sel = IMM_J;
         OPCODE_LUI, OPCODE_AUIPC:  sel = IMM_U;
         OPCODE_BRANCH:             sel = IMM_B;
         OPCODE_STORE:              sel = IMM_S;
         default:                   sel = IMM_I;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID flop bank
// Update priority: flush > stall > load > bubble.
module if_id_register #(
   parameter logic [31:0] NOP_INSTR = cpu_pkg::DEFAULT_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   input  logic        stall_i,
   input  logic        load_i,
   input  logic [31:0] load_pc_i,
   input  logic [31:0] load_instr_i,
   input  logic        load_misaligned_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] instr_o,
   output logic        misaligned_o
);

   logic        valid_q;
   logic [31:0] pc_q;
   logic [31:0] pc_plus4_q;
   logic [31:0] instr_q;
   logic        misaligned_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= 1'b0;
         pc_q         <= 32'h0000_0000;
         pc_plus4_q   <= 32'h0000_0004;
         instr_q      <= NOP_INSTR;
         misaligned_q <= 1'b0;
      end else if (flush_i) begin
         valid_q      <= 1'b0;
         instr_q      <= NOP_INSTR;
         misaligned_q <= 1'b0;
      end else if (!stall_i) begin
         if (load_i) begin
            valid_q      <= 1'b1;
            pc_q         <= load_pc_i;
            pc_plus4_q   <= load_pc_i + 32'd4;
            instr_q      <= load_instr_i;
            misaligned_q <= load_misaligned_i;
         end else begin
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            misaligned_q <= 1'b0;
         end
      end
   end

   assign valid_o      = valid_q;
   assign pc_o         = pc_q;
   assign pc_plus4_o   = pc_plus4_q;
   assign instr_o      = instr_q;
   assign misaligned_o = misaligned_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC, single-outstanding fetch FSM, IF/ID register
// FETCH_MISALIGN_CHECK_EN: trap misaligned PCs in FAULT instead of masking redirect targets.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_instruction,
   output logic        if_id_misaligned
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_pc_q, req_pc_d;
   logic [31:0]  hold_q, hold_d;
   logic         req_valid_q, req_valid_d;
   logic [31:0]  redirect_target;
   logic         req_fire;

   logic         ifid_load;
   logic [31:0]  ifid_pc;
   logic [31:0]  ifid_instr;
   logic         ifid_misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign redirect_target = redirect_pc;
`else
   logic unused_redirect_lsb;
   assign redirect_target     = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

   assign req_fire = imem_req_valid && imem_req_ready;

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      req_pc_d        = req_pc_q;
      hold_d          = hold_q;
      ifid_load       = 1'b0;
      ifid_pc         = req_pc_q;
      ifid_instr      = imem_rsp_data;
      ifid_misaligned = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (redirect_valid) pc_d = redirect_target;
         end
         S_REQ: begin
            if (redirect_valid) begin
               pc_d = redirect_target;
               // A request accepted on the redirect edge is already in flight; drop its response.
               if (req_fire) state_d = S_DRAIN;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            else if (pc_q[1:0] != 2'b00) begin
               if (!stall) begin
                  ifid_load       = 1'b1;
                  ifid_pc         = pc_q;
                  ifid_instr      = NOP_INSTR;
                  ifid_misaligned = 1'b1;
                  state_d         = S_FAULT;
               end
            end
`endif
            else if (req_fire) begin
               req_pc_d = pc_q;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               if (redirect_valid) begin
                  pc_d    = redirect_target;
                  state_d = S_REQ;
               end else if (stall) begin
                  hold_d  = imem_rsp_data;
                  state_d = S_HOLD;
               end else begin
                  ifid_load = 1'b1;
                  pc_d      = req_pc_q + 32'd4;
                  state_d   = S_REQ;
               end
            end else if (redirect_valid) begin
               pc_d    = redirect_target;
               state_d = S_DRAIN;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_d    = redirect_target;
               state_d = S_REQ;
            end else if (!stall) begin
               ifid_load  = 1'b1;
               ifid_instr = hold_q;
               pc_d       = req_pc_q + 32'd4;
               state_d    = S_REQ;
            end
         end
         S_DRAIN: begin
            if (redirect_valid) pc_d = redirect_target;
            if (imem_rsp_valid) state_d = S_REQ;
         end
`ifdef FETCH_MISALIGN_CHECK_EN
         S_FAULT: begin
            if (redirect_valid) begin
               pc_d    = redirect_target;
               state_d = S_REQ;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      req_valid_d = (state_d == S_REQ) && (pc_d[1:0] == 2'b00);
`else
      req_valid_d = (state_d == S_REQ);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         req_pc_q    <= RESET_PC;
         hold_q      <= NOP_INSTR;
         req_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         hold_q      <= hold_d;
         req_valid_q <= req_valid_d;
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_addr      = pc_q;

   if_id_register #(
      .NOP_INSTR(NOP_INSTR)
   ) u_if_id (
      .clk               (clk),
      .rst               (rst),
      .flush_i           (redirect_valid),
      .stall_i           (stall),
      .load_i            (ifid_load),
      .load_pc_i         (ifid_pc),
      .load_instr_i      (ifid_instr),
      .load_misaligned_i (ifid_misaligned),
      .valid_o           (if_id_valid),
      .pc_o              (if_id_pc),
      .pc_plus4_o        (if_id_pc_plus4),
      .instr_o           (if_id_instruction),
      .misaligned_o      (if_id_misaligned)
   );

`ifndef SYNTHESIS
   rsp_only_when_expected: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (state_q == S_WAIT || state_q == S_DRAIN));
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
// Vector table for streaming fetch, scoreboard for IF/ID loads, directed corner sequences.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_instruction;
   logic        if_id_misaligned;

   int n_tests = 0;
   int n_fail  = 0;
   int rsp_delay = 1;

   always #5 clk = ~clk;

   instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
      .clk               (clk),
      .rst               (rst),
      .stall             (stall),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .imem_req_valid    (imem_req_valid),
      .imem_req_ready    (imem_req_ready),
      .imem_addr         (imem_addr),
      .imem_rsp_valid    (imem_rsp_valid),
      .imem_rsp_data     (imem_rsp_data),
      .if_id_valid       (if_id_valid),
      .if_id_pc          (if_id_pc),
      .if_id_pc_plus4    (if_id_pc_plus4),
      .if_id_instruction (if_id_instruction),
      .if_id_misaligned  (if_id_misaligned)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_010C) return 32'h0050_0093;
      return {a[31:2], 2'b11} ^ 32'h00A0_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory: one response per accepted request, rsp_delay edges later.
   initial begin
      logic        acc, pend;
      logic [31:0] a, paddr;
      int          cnt;
      pend = 1'b0; paddr = 32'h0; cnt = 0;
      forever begin
         @(posedge clk);
         acc = !rst && imem_req_valid && imem_req_ready;
         a   = imem_addr;
         #1;
         imem_rsp_valid = 1'b0;
         if (rst) pend = 1'b0;
         else begin
            if (pend) cnt--;
            if (acc) begin
               pend = 1'b1; paddr = a; cnt = rsp_delay - 1;
            end
            if (pend && cnt <= 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(paddr);
               pend = 1'b0;
            end
         end
      end
   end

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        mis;
   } exp_t;
   exp_t exp_q[$];

   // Scoreboard: a fetched word reaches IF/ID on the first edge without stall
   // after its response, unless any redirect occurs between acceptance and load.
   initial begin
      logic        s_stall, s_redir, s_rsp, s_acc, s_rst;
      logic [31:0] s_addr, pend_addr;
      int          pend_st;
      exp_t        e, got;
      pend_st = 0; pend_addr = 32'h0;
      forever begin
         @(posedge clk);
         s_stall = stall; s_redir = redirect_valid; s_rsp = imem_rsp_valid;
         s_acc = imem_req_valid && imem_req_ready; s_addr = imem_addr; s_rst = rst;
         if (s_rst) begin
            pend_st = 0;
            exp_q.delete();
         end else begin
            if (s_redir) pend_st = 0;
            else if (pend_st == 2 || (pend_st == 1 && s_rsp)) begin
               if (s_stall) pend_st = 2;
               else begin
                  e.pc = pend_addr; e.instr = mem_word(pend_addr); e.mis = 1'b0;
                  exp_q.push_back(e);
                  pend_st = 0;
               end
            end
            if (s_acc && !s_redir) begin
               pend_st = 1; pend_addr = s_addr;
            end
         end
         #1;
         if (!rst && !s_rst && !s_stall && !s_redir && if_id_valid) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL sb_unexpected_load: got pc %h instr %h expected no load", if_id_pc, if_id_instruction);
            end else begin
               e = exp_q.pop_front();
               got.pc = if_id_pc; got.instr = if_id_instruction; got.mis = if_id_misaligned;
               check("sb_pc", got.pc, e.pc);
               check("sb_pc_plus4", if_id_pc_plus4, e.pc + 32'd4);
               check("sb_instr", got.instr, e.instr);
               check("sb_misaligned", {31'b0, got.mis}, {31'b0, e.mis});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        ready;
      logic        stall;
      logic        exp_req_valid;
      logic [31:0] exp_addr;
      logic        exp_if_valid;
   } vec_t;

   task automatic check_reset_state(input string tag);
      check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
      check({tag, "_addr"}, imem_addr, 32'h100);
      check({tag, "_if_valid"}, {31'b0, if_id_valid}, 32'h0);
      check({tag, "_if_pc"}, if_id_pc, 32'h0);
      check({tag, "_if_pc4"}, if_id_pc_plus4, 32'h4);
      check({tag, "_if_instr"}, if_id_instruction, 32'h13);
      check({tag, "_if_mis"}, {31'b0, if_id_misaligned}, 32'h0);
   endtask

   initial begin
      vec_t vecs[10];
      vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h100, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h104, 1'b1};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h104, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h104, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h104, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h104, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h108, 1'b1};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h108, 1'b0};
      vecs[9] = '{1'b1, 1'b0, 1'b1, 32'h10C, 1'b1};

      repeat (2) step();
      check_reset_state("reset");
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         imem_req_ready = vecs[i].ready;
         stall          = vecs[i].stall;
         step();
         check($sformatf("vec%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].exp_req_valid});
         check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
         check($sformatf("vec%0d_if_valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].exp_if_valid});
      end

      // Stall while the response arrives: held in HOLD, released when stall drops.
      step();
      check("hold_accept_req_valid", {31'b0, imem_req_valid}, 32'h0);
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         check("hold_if_valid", {31'b0, if_id_valid}, 32'h0);
         check("hold_if_instr", if_id_instruction, 32'h13);
         check("hold_req_valid", {31'b0, imem_req_valid}, 32'h0);
      end
      stall = 1'b0;
      step();
      check("hold_release_valid", {31'b0, if_id_valid}, 32'h1);
      check("hold_release_instr", if_id_instruction, 32'h0050_0093);
      check("hold_release_pc", if_id_pc, 32'h10C);
      check("hold_release_addr", imem_addr, 32'h110);

      // Redirect and stall together: redirect flushes IF/ID.
      imem_req_ready = 1'b0; stall = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h180;
      step();
      check("redir_stall_if_valid", {31'b0, if_id_valid}, 32'h0);
      check("redir_stall_if_instr", if_id_instruction, 32'h13);
      check("redir_stall_addr", imem_addr, 32'h180);
      check("redir_stall_req_valid", {31'b0, imem_req_valid}, 32'h1);
      redirect_valid = 1'b0; stall = 1'b0;

      // Redirect while waiting: the late response is drained and discarded.
      rsp_delay = 2; imem_req_ready = 1'b1;
      step();
      check("wait_redir_accept", {31'b0, imem_req_valid}, 32'h0);
      redirect_valid = 1'b1; redirect_pc = 32'h200; imem_req_ready = 1'b0;
      step();
      redirect_valid = 1'b0;
      check("drain_req_valid", {31'b0, imem_req_valid}, 32'h0);
      check("drain_if_valid", {31'b0, if_id_valid}, 32'h0);
      check("drain_if_instr", if_id_instruction, 32'h13);
      step();
      check("drain_exit_req_valid", {31'b0, imem_req_valid}, 32'h1);
      check("drain_exit_addr", imem_addr, 32'h200);
      check("drain_exit_if_valid", {31'b0, if_id_valid}, 32'h0);

      rsp_delay = 1; imem_req_ready = 1'b1;
      repeat (4) step();
      check("after_drain_addr", imem_addr, 32'h208);

      // PC wraps modulo 2^32.
      imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0; imem_req_ready = 1'b1;
      repeat (2) step();
      check("wrap_addr", imem_addr, 32'h0);
      check("wrap_pc_plus4", if_id_pc_plus4, 32'h0);

      // Misaligned redirect target.
      imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h202;
      step();
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      begin
         exp_t fe;
         check("mis_no_req", {31'b0, imem_req_valid}, 32'h0);
         fe.pc = 32'h202; fe.instr = 32'h13; fe.mis = 1'b1;
         exp_q.push_back(fe);
         step();
         check("mis_flag", {31'b0, if_id_misaligned}, 32'h1);
         check("mis_if_valid", {31'b0, if_id_valid}, 32'h1);
         step();
         check("fault_no_req", {31'b0, imem_req_valid}, 32'h0);
      end
`else
      check("mask_addr", imem_addr, 32'h200);
      check("mask_req_valid", {31'b0, imem_req_valid}, 32'h1);
      check("mask_mis_flag", {31'b0, if_id_misaligned}, 32'h0);
`endif
      redirect_valid = 1'b1; redirect_pc = 32'h300;
      step();
      redirect_valid = 1'b0;
      check("resume_req_valid", {31'b0, imem_req_valid}, 32'h1);
      check("resume_addr", imem_addr, 32'h300);
      imem_req_ready = 1'b1;
      repeat (2) step();
      check("resume_next_addr", imem_addr, 32'h304);

      // Asynchronous reset with a request outstanding.
      step();
      rst = 1'b1;
      #1;
      check_reset_state("async_rst");
      repeat (2) step();
      rst = 1'b0;
      repeat (3) step();
      check("post_rst_addr", imem_addr, 32'h104);
      check("post_rst_if_pc", if_id_pc, 32'h100);

      imem_req_ready = 1'b0;
      repeat (2) step();
      check("sb_drained", exp_q.size(), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
